core_run_ctrl: RTL
==================

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 Parameter MAX_CYCLES, default 1024: RUN cycles allowed before forced stop.
REQ-002 Parameter RESULT_BASE, default 32'h0000_0000: byte address of the first result word in data memory.
REQ-003 Parameter RESULT_WORDS, default 3: number of result words read back (1..15).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  request a run; sampled only in IDLE or DONE.
REQ-007 initAddr  in  32  first instruction address for the run.
REQ-008 tbStart  out  1  core enable; 0 holds the core PC at initInstAddr.
REQ-009 initInstAddr  out  32  latched initAddr, driven to the core.
REQ-010 currInstAddr, nextInstAddr  in  32 each  core PC and next-PC.
REQ-011 dbgRead  out  1  data-memory debug read strobe.
REQ-012 dbgAddr  out  32  debug read byte address.
REQ-013 dbgData  in  32  debug read data, valid in the same cycle as dbgRead.
REQ-014 resultData  out  32; resultIdx  out  4; resultValid  out  1: one read-back word per pulse.
REQ-015 busy, done, timeout  out  1 each; cycleCount  out  32.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN, DUMP and DONE.
REQ-017 IDLE or DONE with start=1 SHALL latch initAddr, clear cycleCount, timeout and done, and enter RUN on the next edge.
REQ-018 tbStart SHALL be 1 exactly while in RUN, and busy SHALL be 1 in RUN and DUMP.
REQ-019 Each RUN cycle SHALL increment cycleCount, including the cycle in which the exit condition is seen.
REQ-020 Halt SHALL be detected when nextInstAddr==currInstAddr (self-loop) in RUN, and the FSM SHALL then enter DUMP.
REQ-021 When cycleCount+1==MAX_CYCLES without a halt, the FSM SHALL enter DUMP with timeout=1.
REQ-022 If halt and timeout occur in the same cycle, halt SHALL win and timeout SHALL stay 0.
REQ-023 DUMP SHALL run for RESULT_WORDS cycles, driving dbgRead=1 and dbgAddr=RESULT_BASE+4*idx with idx going 0..RESULT_WORDS-1.
REQ-024 resultData, resultIdx and resultValid SHALL register dbgData, idx and 1, so each word appears one cycle after its read.
REQ-025 After the last read the FSM SHALL enter DONE; done SHALL be 1 in DONE and hold until the next start.
REQ-026 start in RUN or DUMP SHALL be ignored.
REQ-027 cycleCount SHALL saturate at 32'hFFFF_FFFF.
REQ-028 cycleCount and timeout SHALL hold their values in DUMP and DONE.

Reset
REQ-029 rst_n=0 SHALL, at the next edge, force IDLE with every output 0, including initInstAddr.
REQ-030 Reset SHALL take effect mid-RUN or mid-DUMP with no partial results issued after it.

Structure
REQ-031 A shared package core_ctrl_pkg SHALL hold the state encoding (2-bit) and the default values of MAX_CYCLES, RESULT_BASE and RESULT_WORDS.
REQ-032 One sub-module, run_cycle_counter, SHALL hold the saturating counter with clear and enable and flag cycleCount+1==MAX_CYCLES.
REQ-033 The block SHALL sit beside RISC_V_singleCycle_P1 and drive its tbStart/initInstAddr; the data-memory debug port SHALL be added to that core.

Verification
REQ-034 Matrix-vector program (mat 1..9, vec 1,2,3) with start and initAddr=0 -> halt; resultData 14, 32, 50 at resultIdx 0, 1, 2; done=1; timeout=0.
REQ-035 MAX_CYCLES=16 with a program that never self-loops -> cycleCount=16, timeout=1, tbStart=1 for exactly 16 cycles.
REQ-036 Self-loop at cycle 16 with MAX_CYCLES=16 -> timeout=0, cycleCount=16.
REQ-037 start pulsed in RUN -> no restart; cycleCount is not cleared.
REQ-038 rst_n=0 mid-DUMP after one result word -> the next cycle shows IDLE, all outputs 0, and no further resultValid.
REQ-039 start in DONE with initAddr=32'h40 -> initInstAddr=32'h40, done=0, cycleCount restarts at 1.

Source files
------------

// File: rtl/core_run_ctrl_pkg.sv
// Shared definitions for the run controller: FSM state encoding, parameter
// defaults and the debug-read address helper.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } run_state_e;

    localparam int unsigned DEF_MAX_CYCLES   = 1024;
    localparam logic [31:0] DEF_RESULT_BASE  = 32'h0000_0000;
    localparam int unsigned DEF_RESULT_WORDS = 3;
    localparam int unsigned IDX_W            = 4;

    // Byte address of result word idx; words are 4 bytes apart.
    function automatic logic [31:0] word_addr(input logic [31:0]      base,
                                              input logic [IDX_W-1:0] idx);
        return base + {26'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/core_run_ctrl_if.sv
// Connection between the run controller and the single-cycle core:
// core enable / start PC, PC observation and the data-memory debug port.
interface core_run_ctrl_if;

    logic        tbStart;
    logic [31:0] initInstAddr;
    logic [31:0] currInstAddr;
    logic [31:0] nextInstAddr;
    logic        dbgRead;
    logic [31:0] dbgAddr;
    logic [31:0] dbgData;

    // The controller side.
    modport master (
        output tbStart, initInstAddr, dbgRead, dbgAddr,
        input  currInstAddr, nextInstAddr, dbgData
    );

    // The core side.
    modport slave (
        input  tbStart, initInstAddr, dbgRead, dbgAddr,
        output currInstAddr, nextInstAddr, dbgData
    );

endinterface

// File: rtl/core_run_ctrl_counter.sv
// Saturating RUN-cycle counter with clear and enable; flags the cycle whose
// increment will reach MAX_CYCLES.
module run_cycle_counter
    import core_ctrl_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count,
    output logic        at_limit
);

    logic [31:0] count_q, count_d;

    always_comb begin
        // NOTE: default first so every path assigns count_d -- no latch.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 32'd1;
        end
    end

    // NOTE: state flops use non-blocking assignment; rst_n is sampled on the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    // 33-bit compare so a saturated count can never alias the limit.
    assign at_limit = (({1'b0, count_q} + 33'd1) == 33'(MAX_CYCLES));

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller for the single-cycle core: starts a run, detects halt or
// cycle-budget timeout, then reads the result words back over the debug port.
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter logic [31:0] RESULT_BASE  = DEF_RESULT_BASE,
    parameter int unsigned RESULT_WORDS = DEF_RESULT_WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      initAddr,
    core_run_ctrl_if.master  bus,
    output logic [31:0]      resultData,
    output logic [3:0]       resultIdx,
    output logic             resultValid,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [31:0]      cycleCount
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESULT_WORDS - 1);

    run_state_e       state_q, state_d;
    logic [31:0]      init_addr_q, init_addr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [IDX_W-1:0] res_idx_q, res_idx_d;
    logic             res_valid_q, res_valid_d;

    logic        cnt_clr, cnt_en, at_limit, halt;
    logic        dbg_read;
    logic [31:0] dbg_addr;

    run_cycle_counter #(.MAX_CYCLES(MAX_CYCLES)) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .count    (cycleCount),
        .at_limit (at_limit)
    );

    // A core spinning on a self-branch has finished its program.
    assign halt = (bus.nextInstAddr == bus.currInstAddr);

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        idx_d       = idx_q;
        timeout_d   = timeout_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        res_valid_d = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        dbg_read    = 1'b0;
        dbg_addr    = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    init_addr_d = initAddr;
                    cnt_clr     = 1'b1;
                    timeout_d   = 1'b0;
                    idx_d       = '0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_en = 1'b1;
                // Halt is tested first so it wins over a simultaneous timeout.
                if (halt) begin
                    idx_d   = '0;
                    state_d = ST_DUMP;
                end else if (at_limit) begin
                    timeout_d = 1'b1;
                    idx_d     = '0;
                    state_d   = ST_DUMP;
                end
            end
            ST_DUMP: begin
                dbg_read    = 1'b1;
                dbg_addr    = word_addr(RESULT_BASE, idx_q);
                res_valid_d = 1'b1;
                res_data_d  = bus.dbgData;
                res_idx_d   = idx_q;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            init_addr_q <= '0;
            idx_q       <= '0;
            timeout_q   <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            idx_q       <= idx_d;
            timeout_q   <= timeout_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.tbStart      = (state_q == ST_RUN);
    assign bus.initInstAddr = init_addr_q;
    assign bus.dbgRead      = dbg_read;
    assign bus.dbgAddr      = dbg_addr;

    assign busy        = (state_q == ST_RUN) || (state_q == ST_DUMP);
    assign done        = (state_q == ST_DONE);
    assign timeout     = timeout_q;
    assign resultData  = res_data_q;
    assign resultIdx   = res_idx_q;
    assign resultValid = res_valid_q;

endmodule
